ma_dbreak: RTL and testbench
============================

Name: ma_dbreak

Overview:
- Parametrised data-break (DMA) engine for the PDP-8 memory port.
- Generalises the single-device RK8E break path to NCH device channels with round-robin arbitration.
- Supports three break operations per channel: read, write and increment-memory (add-one, as used by three-cycle-break word counters).
- Sits between the device controllers, the CPU major-state sequencer (break request/grant) and the memory mux ahead of the RAM/SPRAM. While it owns the port, the CPU keeps its own eaddr untouched.

Parameters:
- NCH, 2, number of device channels (1..8).
- AW, 15, memory address width (field + 12-bit address).
- DW, 12, memory word width.
- RDLAT, 1, synchronous RAM read latency in clocks (1 or 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ch_req  in  NCH  per-channel break request; level, held until ch_ack.
- ch_op  in  2*NCH  per-channel op, channel i at [2i+1:2i]: 00 read, 01 write, 10 increment, 11 reserved (treated as read).
- ch_addr  in  AW*NCH  per-channel break address.
- ch_wdata  in  DW*NCH  per-channel write data.
- ch_ack  out  NCH  one-clock completion pulse to the served channel.
- ch_rdata  out  DW  shared data returned by read/increment; valid in the ch_ack cycle and held until the next break.
- ch_ovf  out  1  increment wrapped 7777->0000; valid with ch_ack.
- cpu_brk_req  out  1  request to the CPU to stall at the next major-state boundary.
- cpu_brk_grant  in  1  CPU stalled; level, held while cpu_brk_req is high.
- mem_own  out  1  memory mux select: 1 = this block drives the port.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_we  out  1  memory write strobe, one clock.
- mem_rdata  in  DW  memory read data, RDLAT clocks after address.

Behaviour:
- Reset (asynchronous, active-low): state IDLE, rr_ptr=0, ch_ack=0, ch_ovf=0, ch_rdata=0, cpu_brk_req=0, mem_own=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset asserted mid-break drops mem_we and mem_own immediately and abandons the transfer with no ack. A write already strobed stands.
- States:
  - IDLE: if any ch_req, select the winner as the first requesting channel at or after rr_ptr (wrapping). Latch its index, op, addr and wdata; go to REQ.
  - REQ: cpu_brk_req=1; wait for cpu_brk_grant=1, then go to B0.
  - B0: mem_own=1, mem_addr=latched addr, mem_wdata=latched wdata. Write op: mem_we=1 this cycle, then go to B3. Otherwise go to BW.
  - BW: wait RDLAT-1 extra clocks (none when RDLAT=1), then go to B2.
  - B2: ch_rdata<=mem_rdata. Increment op: mem_wdata=mem_rdata+1 (mod 2^DW), mem_we=1, ovf_tmp=(mem_rdata==all ones). Go to B3.
  - B3: ch_ack[winner]=1 and ch_ovf=ovf_tmp (0 for read/write). cpu_brk_req=0, mem_own=0. rr_ptr<=(winner+1) mod NCH. Go to IDLE.
- Latency from grant high to ack (RDLAT=1): write 2 clocks, read/increment 3 clocks.
- cpu_brk_req stays high continuously from REQ through B3 inclusive.
- mem_own is high B0..B2 and low in B3; the CPU resumes its memory cycle after B3.
- Request parameters are sampled only at IDLE exit. Changes to ch_addr/ch_op/ch_wdata afterwards are ignored. A channel that drops ch_req before grant is still served and acked.
- A channel must drop ch_req in the cycle after ch_ack, or it is re-arbitrated as a new request. Back-to-back breaks need one IDLE clock between them.
- Grant dropping during B0..B3 is a protocol violation; behaviour is undefined.
- ch_op 11 behaves exactly as read.
- Address arithmetic is the device's job; no auto-increment is done here.

Test Plan:
- Write: ch0 op=01, addr=15'o10200, wdata=12'o1234; grant 2 clocks after req -> one mem_we at B0 with addr 10200 / data 1234; ch_ack[0] 2 clocks after grant; read-back gives 1234.
- Read: preload 15'o00017=12'o5555; ch1 op=00 addr 00017 -> ch_rdata=5555 with ch_ack[1], mem_we never asserted.
- Increment wrap: preload 15'o07770=12'o7777; op=10 -> memory becomes 0000, ch_ovf=1 with ack. Then preload 0041 -> 0042, ch_ovf=0.
- Arbitration: ch0 and ch1 held requesting continuously (NCH=2) -> service order 0,1,0,1. With rr_ptr=1 and simultaneous requests, ch1 is served first.
- Grant delay: hold cpu_brk_grant low 10 clocks -> mem_own and mem_we stay 0; cpu_brk_req stays 1; transfer completes normally after grant.
- Reset mid-break: assert reset in B2 of an increment -> mem_we drops immediately, no ch_ack, memory unchanged; after release, state IDLE and rr_ptr=0.

Source files
------------

// File: rtl/ma_dbreak_if.sv
// rtl/ma_dbreak_if.sv - channel, CPU break handshake and memory port bundle for ma_dbreak
interface ma_dbreak_if #(
    parameter int NCH = 2,
    parameter int AW  = 15,
    parameter int DW  = 12
);
    logic [NCH-1:0]    ch_req;
    logic [2*NCH-1:0]  ch_op;
    logic [AW*NCH-1:0] ch_addr;
    logic [DW*NCH-1:0] ch_wdata;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_rdata;
    logic              ch_ovf;
    logic              cpu_brk_req;
    logic              cpu_brk_grant;
    logic              mem_own;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;

    modport master (
        input  ch_req, ch_op, ch_addr, ch_wdata, cpu_brk_grant, mem_rdata,
        output ch_ack, ch_rdata, ch_ovf, cpu_brk_req, mem_own, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output ch_req, ch_op, ch_addr, ch_wdata, cpu_brk_grant, mem_rdata,
        input  ch_ack, ch_rdata, ch_ovf, cpu_brk_req, mem_own, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/ma_dbreak.sv
// rtl/ma_dbreak.sv - round-robin data-break engine (read/write/increment) for the PDP-8 memory port
module ma_dbreak #(
    parameter int NCH   = 2,
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int RDLAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    ma_dbreak_if.master bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_B0,
        S_BW,
        S_B2,
        S_B3
    } state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   arb_idx;
    logic            arb_hit;
    logic [1:0]      lat_op;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [DW-1:0]   rdata_q;
    logic            ovf_tmp;
    logic [1:0]      bw_cnt;
    logic            op_wr;
    logic            op_inc;

    assign op_wr  = (lat_op == 2'b01);
    assign op_inc = (lat_op == 2'b10);

    // Scan from the farthest offset down so the nearest requester at/after rr_ptr wins.
    always_comb begin
        int k;
        arb_hit = 1'b0;
        arb_idx = '0;
        k       = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            k = int'(rr_ptr) + i;
            if (k >= NCH) k = k - NCH;
            if (bus.ch_req[IW'(k)]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            win_idx   <= '0;
            lat_op    <= 2'b00;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            ovf_tmp   <= 1'b0;
            bw_cnt    <= 2'd0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && arb_hit) begin
                win_idx   <= arb_idx;
                lat_op    <= bus.ch_op[2*arb_idx +: 2];
                lat_addr  <= bus.ch_addr[arb_idx*AW +: AW];
                lat_wdata <= bus.ch_wdata[arb_idx*DW +: DW];
                ovf_tmp   <= 1'b0;
            end
            if (state == S_B0) bw_cnt <= 2'd0;
            if (state == S_BW) bw_cnt <= bw_cnt + 2'd1;
            if (state == S_B2) begin
                rdata_q <= bus.mem_rdata;
                ovf_tmp <= op_inc && (&bus.mem_rdata);
            end
            if (state == S_B3) begin
                rr_ptr <= (win_idx == IW'(NCH - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (arb_hit) state_nx = S_REQ;
            S_REQ:  if (bus.cpu_brk_grant) state_nx = S_B0;
            S_B0: begin
                if (op_wr)          state_nx = S_B3;
                else if (RDLAT > 1) state_nx = S_BW;
                else                state_nx = S_B2;
            end
            S_BW:   if (bw_cnt == 2'(RDLAT - 2)) state_nx = S_B2;
            S_B2:   state_nx = S_B3;
            S_B3:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops the strobe at once.
    always_comb begin
        bus.cpu_brk_req = (state != S_IDLE);
        bus.mem_own     = (state == S_B0) || (state == S_BW) || (state == S_B2);
        bus.mem_addr    = lat_addr;
        bus.mem_wdata   = (state == S_B2) ? bus.mem_rdata + DW'(1) : lat_wdata;
        bus.mem_we      = ((state == S_B0) && op_wr) || ((state == S_B2) && op_inc);
        bus.ch_ack      = (state == S_B3) ? (NCH'(1) << win_idx) : '0;
        bus.ch_ovf      = (state == S_B3) && ovf_tmp;
        bus.ch_rdata    = rdata_q;
    end
endmodule

// File: tb/tb_ma_dbreak.sv
// tb/tb_ma_dbreak.sv - directed self-checking bench for ma_dbreak
module tb_ma_dbreak;
    localparam int NCH   = 2;
    localparam int AW    = 15;
    localparam int DW    = 12;
    localparam int RDLAT = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ma_dbreak_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus();

    ma_dbreak #(.NCH(NCH), .AW(AW), .DW(DW), .RDLAT(RDLAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] rd_q1, rd_q2;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we)          ram[pre_addr]     <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rd_q1 <= ram[bus.mem_addr];
        rd_q2 <= rd_q1;
    end
    assign bus.mem_rdata = (RDLAT == 2) ? rd_q2 : rd_q1;

    int n_checks = 0;
    int n_fail   = 0;

    int            r_who, r_lat, r_wes, r_viol;
    logic [DW-1:0] r_rd, r_wd;
    logic [AW-1:0] r_wa;
    logic          r_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ch_op[2*ch +: 2]     = op;
        bus.ch_addr[ch*AW +: AW] = a;
        bus.ch_wdata[ch*DW +: DW] = d;
    endtask

    // drop: 0 = release winner after ack, 1 = keep all requests, 2 = release all
    task automatic serve(input int gdelay, input int drop, input bit scramble);
        int t;
        t = 0;
        while (!bus.cpu_brk_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("brk_req_rise", bus.cpu_brk_req, 1);
        if (scramble) begin
            bus.ch_addr  = ~bus.ch_addr;
            bus.ch_wdata = ~bus.ch_wdata;
            bus.ch_op    = ~bus.ch_op;
        end
        r_viol = 0;
        repeat (gdelay) begin
            if (bus.mem_own || bus.mem_we || !bus.cpu_brk_req) r_viol++;
            @(negedge clk);
        end
        bus.cpu_brk_grant = 1'b1;
        r_lat = 0;
        r_wes = 0;
        r_wa  = '0;
        r_wd  = '0;
        while (bus.ch_ack == '0 && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
            if (bus.mem_we) begin
                r_wes++;
                r_wa = bus.mem_addr;
                r_wd = bus.mem_wdata;
            end
        end
        r_who = -1;
        for (int i = 0; i < NCH; i++)
            if (bus.ch_ack[i]) r_who = (r_who == -1) ? i : -2;
        r_rd  = bus.ch_rdata;
        r_ovf = bus.ch_ovf;
        if (bus.mem_own || !bus.cpu_brk_req) r_viol++;
        if (drop == 2)                    bus.ch_req = '0;
        else if (drop == 0 && r_who >= 0) bus.ch_req[r_who] = 1'b0;
        @(negedge clk);
        bus.cpu_brk_grant = 1'b0;
        if (bus.ch_ack != '0 || bus.cpu_brk_req) r_viol++;
    endtask

    initial begin
        int t;
        int ack_seen;
        bus.ch_req        = '0;
        bus.ch_op         = '0;
        bus.ch_addr       = '0;
        bus.ch_wdata      = '0;
        bus.cpu_brk_grant = 1'b0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        repeat (3) @(negedge clk);

        check("rst_ack",   bus.ch_ack, 0);
        check("rst_rdata", bus.ch_rdata, 0);
        check("rst_ovf",   bus.ch_ovf, 0);
        check("rst_breq",  bus.cpu_brk_req, 0);
        check("rst_own",   bus.mem_own, 0);
        check("rst_we",    bus.mem_we, 0);
        check("rst_addr",  bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        reset = 1'b1;
        @(negedge clk);

        // write, grant two clocks after request
        set_ch(0, 2'b01, 15'o10200, 12'o1234);
        bus.ch_req[0] = 1'b1;
        serve(2, 0, 0);
        check("wr_who",  r_who, 0);
        check("wr_lat",  r_lat, 2);
        check("wr_wes",  r_wes, 1);
        check("wr_addr", r_wa, 15'o10200);
        check("wr_data", r_wd, 12'o1234);
        check("wr_ovf",  r_ovf, 0);
        check("wr_viol", r_viol, 0);
        check("wr_mem",  ram[15'o10200], 12'o1234);

        // read on ch1
        preload(15'o00017, 12'o5555);
        set_ch(1, 2'b00, 15'o00017, 12'o7070);
        bus.ch_req[1] = 1'b1;
        serve(0, 0, 0);
        check("rd_who",   r_who, 1);
        check("rd_lat",   r_lat, 3);
        check("rd_data",  r_rd, 12'o5555);
        check("rd_wes",   r_wes, 0);
        check("rd_viol",  r_viol, 0);
        check("rd_hold",  bus.ch_rdata, 12'o5555);

        // reserved op behaves as read; read back the earlier write
        set_ch(0, 2'b11, 15'o10200, 12'o7777);
        bus.ch_req[0] = 1'b1;
        serve(0, 0, 0);
        check("op11_who",  r_who, 0);
        check("op11_data", r_rd, 12'o1234);
        check("op11_wes",  r_wes, 0);
        check("op11_mem",  ram[15'o10200], 12'o1234);

        // increment wrap
        preload(15'o07770, 12'o7777);
        set_ch(1, 2'b10, 15'o07770, 12'o0000);
        bus.ch_req[1] = 1'b1;
        serve(0, 0, 0);
        check("incw_who",  r_who, 1);
        check("incw_lat",  r_lat, 3);
        check("incw_rd",   r_rd, 12'o7777);
        check("incw_ovf",  r_ovf, 1);
        check("incw_wes",  r_wes, 1);
        check("incw_wa",   r_wa, 15'o07770);
        check("incw_wd",   r_wd, 12'o0000);
        check("incw_mem",  ram[15'o07770], 12'o0000);

        // increment without wrap
        preload(15'o00200, 12'o0041);
        set_ch(0, 2'b10, 15'o00200, 12'o0000);
        bus.ch_req[0] = 1'b1;
        serve(0, 0, 0);
        check("inc_who", r_who, 0);
        check("inc_rd",  r_rd, 12'o0041);
        check("inc_ovf", r_ovf, 0);
        check("inc_mem", ram[15'o00200], 12'o0042);

        // grant held off 10 clocks, request fields scrambled after IDLE exit
        set_ch(0, 2'b01, 15'o00300, 12'o4321);
        bus.ch_req[0] = 1'b1;
        serve(10, 0, 1);
        check("gd_viol", r_viol, 0);
        check("gd_who",  r_who, 0);
        check("gd_lat",  r_lat, 2);
        check("gd_wes",  r_wes, 1);
        check("gd_wa",   r_wa, 15'o00300);
        check("gd_wd",   r_wd, 12'o4321);
        check("gd_mem",  ram[15'o00300], 12'o4321);

        // simultaneous requests with rr_ptr=1: ch1 first
        set_ch(0, 2'b00, 15'o10200, 12'o0000);
        set_ch(1, 2'b00, 15'o00017, 12'o0000);
        bus.ch_req = 2'b11;
        serve(1, 0, 0);
        check("sim_first",    r_who, 1);
        check("sim_first_rd", r_rd, 12'o5555);
        serve(0, 0, 0);
        check("sim_second",    r_who, 0);
        check("sim_second_rd", r_rd, 12'o1234);

        // one ch1 break brings rr_ptr back to 0
        bus.ch_req[1] = 1'b1;
        serve(0, 0, 0);
        check("rr_set_who", r_who, 1);

        // both held continuously: 0,1,0,1
        bus.ch_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            serve(0, (k == 3) ? 2 : 1, 0);
            check($sformatf("rr_order_%0d", k), r_who, k % 2);
        end

        // ch0 once more so rr_ptr=1 going into the reset test
        bus.ch_req[0] = 1'b1;
        serve(0, 0, 0);
        check("pre_rst_who", r_who, 0);

        // reset in B2 of an increment
        preload(15'o00100, 12'o0123);
        set_ch(0, 2'b10, 15'o00100, 12'o0000);
        bus.ch_req = 2'b01;
        t = 0;
        while (!bus.cpu_brk_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mrst_breq", bus.cpu_brk_req, 1);
        bus.cpu_brk_grant = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mrst_we_b2", bus.mem_we, 1);
        check("mrst_wd_b2", bus.mem_wdata, 12'o0124);
        reset = 1'b0;
        #1;
        check("mrst_we_drop",  bus.mem_we, 0);
        check("mrst_own_drop", bus.mem_own, 0);
        check("mrst_breq_drop", bus.cpu_brk_req, 0);
        ack_seen = 0;
        bus.ch_req = '0;
        bus.cpu_brk_grant = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.ch_ack != '0) ack_seen++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.ch_ack != '0) ack_seen++;
        end
        check("mrst_no_ack", ack_seen, 0);
        check("mrst_mem",    ram[15'o00100], 12'o0123);
        check("mrst_idle",   bus.cpu_brk_req, 0);

        // rr_ptr back at 0: simultaneous requests serve ch0 first
        set_ch(0, 2'b00, 15'o00100, 12'o0000);
        set_ch(1, 2'b00, 15'o00017, 12'o0000);
        bus.ch_req = 2'b11;
        serve(0, 0, 0);
        check("post_rst_first", r_who, 0);
        check("post_rst_rd",    r_rd, 12'o0123);
        serve(0, 0, 0);
        check("post_rst_second", r_who, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
